// File: rtl/serial_right_shifter.sv
// serial_right_shifter
//
// Multi-cycle right shifter: captures an operand, shift amount and mode on a
// start strobe, shifts right one bit per clock, then presents the result on
// y together with a one-cycle done pulse.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request strobe, only looked at while idle
//   a      - operand, captured when start is accepted
//   s      - shift amount (0 .. 2^SW-1), captured when start is accepted
//   mode   - 00 logical, 01 arithmetic, 10 rotate, 11 logical
//   busy   - high whenever an operation is in progress
//   done   - one-cycle pulse, y carries the new result
//   y      - registered result, held until the next completion or reset
module serial_right_shifter #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [SW-1:0] s,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  y
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  logic [1:0]    state;
  logic [W-1:0]  work;
  logic [SW-1:0] cnt;
  logic [1:0]    mode_r;
  logic [W-1:0]  y_r;

  // One-bit right shift; only the bit entering the MSB depends on the mode.
  // Mode 11 falls into the logical case.
  function automatic logic [W-1:0] shift_step(input logic [W-1:0] v,
                                              input logic [1:0]   m);
    logic msb_in;
    case (m)
      MODE_ARITH:  msb_in = v[W-1];
      MODE_ROTATE: msb_in = v[0];
      default:     msb_in = 1'b0;
    endcase
    return {msb_in, v[W-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      mode_r <= 2'b00;
      y_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work   <= a;
            cnt    <= s;
            mode_r <= mode;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work <= shift_step(work, mode_r);
            cnt  <= cnt - SW'(1);
          end else begin
            y_r   <= work;
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the registered state, so start has no
  // combinational path to them and reset clears them immediately.
  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign y    = y_r;

endmodule
